stage1_fetch_queue: RTL and testbench
=====================================

Name: stage1_fetch_queue

Overview:
- Parametrised successor to the single-entry fetch stage.
- Owns the PC, issues instruction-memory addresses, resolves branch redirects, and buffers fetched {instruction, PC} pairs in a DEPTH-entry FIFO.
- Feeds decode (stage 2) through a valid/ready handshake, so decode stalls no longer lose instructions.
- Sits between the combinational-read instruction memory and the IF/ID boundary.

Parameters:
- ADDR_W, 64, PC and address width (LEGV8 integer size).
- INSTR_W, 32, instruction width.
- DEPTH, 4, fetch queue entries; power of two, >= 2.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- imem_addr  out  ADDR_W  address to instruction memory; equals the current PC.
- imem_rdata  in  INSTR_W  instruction at imem_addr; combinational, same cycle.
- branch_flag  in  1  conditional-branch indication from execute.
- zero_flag  in  1  ALU zero result from execute.
- uncond_branch_flag  in  1  unconditional-branch indication from execute.
- branch_target  in  ADDR_W  redirect address.
- if_id_valid  out  1  queue head holds a valid entry.
- if_id_ready  in  1  decode accepts the head this cycle.
- if_id_instr  out  INSTR_W  head instruction.
- if_id_pc  out  ADDR_W  PC of head instruction.
- fetch_fault  out  1  sticky misaligned-redirect flag; tied 0 when the optional feature is off.

Behaviour:
- Reset (async, active-high):
  - PC = RESET_PC; queue count = 0; read/write pointers = 0.
  - if_id_valid = 0; if_id_instr = 0; if_id_pc = 0; fetch_fault = 0.
- redirect = (branch_flag & zero_flag) | uncond_branch_flag, evaluated each cycle.
- pop = if_id_valid & if_id_ready.
  - Head entry is consumed on the clock edge.
  - if_id_valid = (count != 0).
  - Outputs come straight from the head entry; no added latency. An entry pushed at edge N is visible at the head after edge N if the queue was empty.
- push = !redirect & (count < DEPTH | pop).
  - Writes {imem_rdata, PC} at the write pointer.
  - PC advances to PC + PC_STEP, modulo 2^ADDR_W; wrap from all-ones-minus-3 to 0 is legal.
- Queue full (count == DEPTH) and no pop: no push; PC holds; imem_addr stable.
- Full with pop in the same cycle: push and pop both occur; count stays DEPTH.
- Empty queue: if_id_valid = 0; if_id_ready is ignored.
- Redirect cycle:
  - A pop in this cycle completes (decode keeps that instruction).
  - All remaining entries are flushed: count = 0, pointers = 0.
  - PC = branch_target; no push this cycle.
  - First post-redirect fetch is pushed on the next edge; if_id_valid rises one cycle later (2-cycle redirect bubble).
- Back-to-back redirects: the last one wins; each flushes the queue again.
- Pointers wrap modulo DEPTH. count width is clog2(DEPTH+1); it never exceeds DEPTH or drops below 0.
- Reset asserted mid-operation clears everything immediately, including entries in flight. Fetch resumes at RESET_PC on the first edge after deassertion.
- branch_target low bits are used as given; alignment handling is defined under Optional Feature.

Optional Feature:
- Macro: LEGV8_FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with branch_target[1:0] != 0 is not taken. Queue is still flushed; PC holds its current value.
  - fetch_fault is set and stays 1 until reset.
  - While fetch_fault = 1, push is disabled. The queue drains normally, then if_id_valid stays 0.
- Undefined:
  - branch_target[1:0] is forced to 2'b00 on redirect.
  - fetch_fault is tied 0; no fetch halt.

Test Plan:
- Reset, hold if_id_ready=1, memory returns instr = addr>>2 -> if_id_pc sequence 0,4,8,12...; valid from 2nd cycle; no gaps.
- if_id_ready=0 for 10 cycles (DEPTH=4) -> count saturates at 4, imem_addr holds 0x10. Then release ready -> pcs 0,4,8,12,0x10 delivered in order, none lost or duplicated.
- Queue holding pcs 0x20..0x2C, uncond_branch_flag=1, target 0x100, head popped in the same cycle -> 0x20 accepted, rest flushed. Next valid output pc=0x100 two cycles later.
- branch_flag=1, zero_flag=0 -> no redirect, sequential fetch continues. Same with zero_flag=1 -> redirect taken.
- RESET_PC = 2^64-8 -> pcs FFFF..F8, FFFF..FC, 0, 4 (wrap).
- Macro defined, redirect to 0x102 -> fetch_fault=1, PC unchanged, queue empty, valid stays 0. Macro undefined, same stimulus -> next pc 0x100, fault=0.

Source files
------------

// File: rtl/stage1_fetch_queue.sv
// Fetch stage: owns the PC, drives instruction memory, resolves redirects and buffers
// {instr, pc} pairs in a DEPTH-entry FIFO toward decode. Optional: LEGV8_FETCH_MISALIGN_TRAP_EN.
module stage1_fetch_queue #(
  parameter int unsigned           ADDR_W   = 64,
  parameter int unsigned           INSTR_W  = 32,
  parameter int unsigned           DEPTH    = 4,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0,
  parameter int unsigned           PC_STEP  = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               branch_flag_i,
  input  logic               zero_flag_i,
  input  logic               uncond_branch_flag_i,
  input  logic [ADDR_W-1:0]  branch_target_i,
  output logic               if_id_valid_o,
  input  logic               if_id_ready_i,
  output logic [INSTR_W-1:0] if_id_instr_o,
  output logic [ADDR_W-1:0]  if_id_pc_o,
  output logic               fetch_fault_o
);

  localparam int unsigned       PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned       CntW     = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0]   DepthCnt = CntW'(DEPTH);
  localparam logic [ADDR_W-1:0] PcStep   = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               fault_q, fault_d;
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];

  logic               redirect;
  logic               pop;
  logic               push;
  logic               misaligned;
  logic [ADDR_W-1:0]  target_pc;

  always_comb begin
    redirect = (branch_flag_i & zero_flag_i) | uncond_branch_flag_i;
    pop      = (count_q != '0) & if_id_ready_i;
`ifdef LEGV8_FETCH_MISALIGN_TRAP_EN
    misaligned = (branch_target_i[1:0] != 2'b00);
    target_pc  = branch_target_i;
`else
    misaligned = 1'b0;
    target_pc  = branch_target_i & ~ADDR_W'(3);
`endif
    // A full queue can still accept a fetch when the head leaves on the same edge.
    push = ~redirect & ~fault_q & ((count_q != DepthCnt) | pop);
  end

  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    fault_d  = fault_q;
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      fault_d  = fault_q | misaligned;
      if (!misaligned) begin
        pc_d = target_pc;
      end
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        pc_d     = pc_q + PcStep;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      fault_q  <= fault_d;
    end
  end

  // Storage needs no reset: outputs are masked whenever the queue is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata_i;
      pc_mem_q[wr_ptr_q]    <= pc_q;
    end
  end

  always_comb begin
    imem_addr_o   = pc_q;
    if_id_valid_o = (count_q != '0);
    if_id_instr_o = if_id_valid_o ? instr_mem_q[rd_ptr_q] : '0;
    if_id_pc_o    = if_id_valid_o ? pc_mem_q[rd_ptr_q] : '0;
    fetch_fault_o = fault_q;
  end

endmodule

// File: tb/tb_stage1_fetch_queue.sv
// Bench for stage1_fetch_queue: queue-based reference model compared every cycle, plus
// directed scenarios with literal expectations (result depends on LEGV8_FETCH_MISALIGN_TRAP_EN).
module tb_stage1_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        branch_flag, zero_flag, uncond;
  logic [63:0] target;
  logic        valid, ready, fault;
  logic [31:0] instr;
  logic [63:0] head_pc;

  logic [63:0] w_addr, w_pc;
  logic [31:0] w_rdata, w_instr;
  logic        w_valid, w_fault;

  int n_pass = 0;
  int n_chk  = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  assign imem_rdata = 32'(imem_addr >> 2);
  assign w_rdata    = 32'(w_addr >> 2);

  stage1_fetch_queue #(.DEPTH(DEPTH)) u_dut (
    .clk_i(clk), .reset_i(rst), .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata),
    .branch_flag_i(branch_flag), .zero_flag_i(zero_flag), .uncond_branch_flag_i(uncond),
    .branch_target_i(target), .if_id_valid_o(valid), .if_id_ready_i(ready),
    .if_id_instr_o(instr), .if_id_pc_o(head_pc), .fetch_fault_o(fault)
  );

  stage1_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) u_wrap (
    .clk_i(clk), .reset_i(rst), .imem_addr_o(w_addr), .imem_rdata_i(w_rdata),
    .branch_flag_i(1'b0), .zero_flag_i(1'b0), .uncond_branch_flag_i(1'b0),
    .branch_target_i(64'h0), .if_id_valid_o(w_valid), .if_id_ready_i(1'b1),
    .if_id_instr_o(w_instr), .if_id_pc_o(w_pc), .fetch_fault_o(w_fault)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model: a queue of fetched PCs, a PC and a sticky fault bit.
  logic [63:0] m_q[$];
  logic [63:0] m_pc;
  bit          m_fault;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_pc    = 64'h0;
      m_fault = 1'b0;
    end else begin
      if (m_q.size() != 0 && ready) void'(m_q.pop_front());
      if ((branch_flag && zero_flag) || uncond) begin
        m_q.delete();
`ifdef LEGV8_FETCH_MISALIGN_TRAP_EN
        if (target[1:0] != 2'b00) m_fault = 1'b1;
        else m_pc = target;
`else
        m_pc = {target[63:2], 2'b00};
`endif
      end else if (!m_fault && m_q.size() < DEPTH) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 64'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("model_addr", imem_addr, m_pc);
      check("model_valid", {63'h0, valid}, {63'h0, m_q.size() != 0});
      check("model_fault", {63'h0, fault}, {63'h0, m_fault});
      if (m_q.size() != 0) begin
        check("model_pc", head_pc, m_q[0]);
        check("model_instr", {32'h0, instr}, {32'h0, 32'(m_q[0] >> 2)});
      end else begin
        check("model_pc_empty", head_pc, 64'h0);
        check("model_instr_empty", {32'h0, instr}, 64'h0);
      end
    end
  end

  initial begin
    rst = 1'b1; ready = 1'b1; branch_flag = 1'b0; zero_flag = 1'b0; uncond = 1'b0;
    target = 64'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {63'h0, valid}, 64'h0);
    check("rst_addr", imem_addr, 64'h0);
    check("rst_pc", head_pc, 64'h0);
    check("rst_instr", {32'h0, instr}, 64'h0);
    check("rst_fault", {63'h0, fault}, 64'h0);
    check("rst_wrap_addr", w_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Streaming with ready held high, plus PC wrap on the second instance.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("seq_valid", {63'h0, valid}, 64'h1);
      check("seq_pc", head_pc, 64'(4 * i));
      check("seq_instr", {32'h0, instr}, 64'(i));
      check("wrap_pc", w_pc, 64'hFFFF_FFFF_FFFF_FFF8 + 64'(4 * i));
    end

    // Decode stall: queue fills, PC freezes at 0x10, then drains in order.
    rst = 1'b1; ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("full_addr", imem_addr, 64'h10);
    check("full_head", head_pc, 64'h0);
    ready = 1'b1;
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      check("drain_pc", head_pc, 64'(4 * i));
    end

    // Fill with 0x20..0x2C, then redirect while the head is popped.
    ready = 1'b0; uncond = 1'b1; target = 64'h20;
    @(negedge clk);
    uncond = 1'b0;
    repeat (5) @(negedge clk);
    check("q20_addr", imem_addr, 64'h30);
    check("q20_head", head_pc, 64'h20);
    ready = 1'b1; uncond = 1'b1; target = 64'h100;
    @(negedge clk);
    uncond = 1'b0;
    check("redir_bubble_valid", {63'h0, valid}, 64'h0);
    check("redir_addr", imem_addr, 64'h100);
    @(negedge clk);
    check("redir_valid", {63'h0, valid}, 64'h1);
    check("redir_pc", head_pc, 64'h100);
    check("redir_instr", {32'h0, instr}, 64'h40);

    // Conditional branch: not taken without zero, taken with it.
    branch_flag = 1'b1; zero_flag = 1'b0; target = 64'h200;
    @(negedge clk);
    branch_flag = 1'b0;
    check("bnz_addr", imem_addr, 64'h108);
    check("bnz_pc", head_pc, 64'h104);
    branch_flag = 1'b1; zero_flag = 1'b1; target = 64'h300;
    @(negedge clk);
    branch_flag = 1'b0; zero_flag = 1'b0;
    check("bz_addr", imem_addr, 64'h300);
    check("bz_valid", {63'h0, valid}, 64'h0);

    // Back-to-back redirects: the last target wins.
    uncond = 1'b1; target = 64'h400;
    @(negedge clk);
    target = 64'h500;
    @(negedge clk);
    uncond = 1'b0;
    check("b2b_addr", imem_addr, 64'h500);
    @(negedge clk);
    check("b2b_pc", head_pc, 64'h500);

    // Redirect on a full queue with no pop.
    ready = 1'b0;
    repeat (6) @(negedge clk);
    uncond = 1'b1; target = 64'h600;
    @(negedge clk);
    uncond = 1'b0; ready = 1'b1;
    check("full_redir_valid", {63'h0, valid}, 64'h0);
    repeat (3) @(negedge clk);

    // Misaligned redirect straight after reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; uncond = 1'b1; target = 64'h102;
    @(negedge clk);
    uncond = 1'b0;
`ifdef LEGV8_FETCH_MISALIGN_TRAP_EN
    check("mis_fault", {63'h0, fault}, 64'h1);
    check("mis_addr", imem_addr, 64'h0);
    check("mis_valid", {63'h0, valid}, 64'h0);
    repeat (3) @(negedge clk);
    check("mis_hold_valid", {63'h0, valid}, 64'h0);
    check("mis_hold_addr", imem_addr, 64'h0);
`else
    check("mis_fault", {63'h0, fault}, 64'h0);
    check("mis_addr", imem_addr, 64'h100);
    check("mis_valid", {63'h0, valid}, 64'h0);
    @(negedge clk);
    check("mis_next_pc", head_pc, 64'h100);
`endif
    @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
